// File: rtl/miscv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package miscv_pkg;

  localparam int XLEN = 16;

  localparam logic [XLEN-1:0] PC_INC    = 16'd2;
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;
  localparam logic [XLEN-1:0] RESET_PC  = 16'h0000;

  // Fetch FSM: FETCH issues a read of PC, HOLD parks with a dropped
  // response until the downstream stall lifts.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

  // Next-PC source chosen by the fetch FSM.
  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_INC    = 2'd1,
    PC_SEL_BRANCH = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/if_pc_gen.sv
// Program counter register with next-PC selection (hold/increment/branch).
// Reset value is applied asynchronously; increments wrap modulo 2^16.
module if_pc_gen
  import miscv_pkg::*;
#(
  parameter logic [XLEN-1:0] INIT_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  // Select the next fetch address; branch targets are forced half-word aligned.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_SEL_INC:    pc_next = pc + PC_INC;
      PC_SEL_BRANCH: pc_next = {target[XLEN-1:1], 1'b0};
      default:       pc_next = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= INIT_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues reads at PC, delivers one instruction
// bundle per cycle into IF/ID, parks in HOLD when a response arrives while
// the current bundle is still stalled downstream, and redirects on branch.
//
//   state | meaning
//   FETCH | MemReq=1 at MemAddr=PC, waiting for / accepting MemReady
//   HOLD  | response was dropped (bundle not consumed); no request until Stall=0
module if_fetch #(
  parameter logic [15:0] RESET_PC  = miscv_pkg::RESET_PC,
  parameter logic [15:0] NOP_INSTR = miscv_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemReady,
  input  logic [15:0] MemData,
  output logic [15:0] FPC,
  output logic [15:0] FPCP2,
  output logic [15:0] FIR,
  output logic        FValid
);

  miscv_pkg::fetch_state_t state, state_next;
  miscv_pkg::pc_sel_t      pc_sel;
  logic [15:0]             pc;
  logic                    load;
  logic                    clear;
  logic                    consumed;

  if_pc_gen #(
    .INIT_PC(RESET_PC)
  ) u_pc_gen (
    .clk   (CLK),
    .rst_n (Reset),
    .sel   (pc_sel),
    .target(BranchTarget),
    .pc    (pc)
  );

  assign consumed = FValid & ~Stall;
  assign MemReq   = (state == miscv_pkg::ST_FETCH);
  assign MemAddr  = pc;

  // Next state, PC source and bundle load/clear decisions; branch wins over all.
  always_comb begin
    state_next = state;
    pc_sel     = miscv_pkg::PC_SEL_HOLD;
    load       = 1'b0;
    clear      = 1'b0;
    if (BranchTaken) begin
      state_next = miscv_pkg::ST_FETCH;
      pc_sel     = miscv_pkg::PC_SEL_BRANCH;
      clear      = 1'b1;
    end else begin
      case (state)
        miscv_pkg::ST_FETCH: begin
          if (MemReady) begin
            if (!FValid || !Stall) begin
              load   = 1'b1;
              pc_sel = miscv_pkg::PC_SEL_INC;
            end else begin
              state_next = miscv_pkg::ST_HOLD;
            end
          end else begin
            clear = consumed;
          end
        end
        miscv_pkg::ST_HOLD: begin
          // Leaving HOLD is the edge where the parked bundle is consumed.
          if (!Stall) begin
            state_next = miscv_pkg::ST_FETCH;
            clear      = consumed;
          end
        end
        default: state_next = miscv_pkg::ST_FETCH;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= miscv_pkg::ST_FETCH;
    else        state <= state_next;
  end

  // IF/ID bundle registers; an invalid bundle always carries the bubble.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      FPC    <= 16'h0000;
      FPCP2  <= 16'h0000;
      FIR    <= NOP_INSTR;
      FValid <= 1'b0;
    end else if (load) begin
      FPC    <= pc;
      FPCP2  <= pc + miscv_pkg::PC_INC;
      FIR    <= MemData;
      FValid <= 1'b1;
    end else if (clear) begin
      FIR    <= NOP_INSTR;
      FValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_if_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0000;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemReady;
  logic [15:0] MemData;
  logic [15:0] FPC;
  logic [15:0] FPCP2;
  logic [15:0] FIR;
  logic        FValid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: next fetch address, the delivered bundle, and whether
  // a response has been dropped and fetching is paused until the stall lifts.
  logic [15:0] m_pc, m_fpc, m_fpcp2, m_fir;
  logic        m_fv, m_paused;

  always #5 CLK = ~CLK;

  if_fetch #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemReady    (MemReady),
    .MemData     (MemData),
    .FPC         (FPC),
    .FPCP2       (FPCP2),
    .FIR         (FIR),
    .FValid      (FValid)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_fpc    = 16'h0000;
    m_fpcp2  = 16'h0000;
    m_fir    = NOP;
    m_fv     = 1'b0;
    m_paused = 1'b0;
  endtask

  // Apply one clock edge of the fetch rules to the model.
  task automatic model_edge();
    logic bundle_free;
    bundle_free = !m_fv || !Stall;
    if (BranchTaken) begin
      m_pc     = BranchTarget & 16'hFFFE;
      m_fv     = 1'b0;
      m_fir    = NOP;
      m_paused = 1'b0;
    end else if (m_paused) begin
      if (!Stall) begin
        m_paused = 1'b0;
        m_fv     = 1'b0;
        m_fir    = NOP;
      end
    end else if (MemReady && bundle_free) begin
      m_fpc   = m_pc;
      m_fpcp2 = 16'(m_pc + 16'd2);
      m_fir   = MemData;
      m_fv    = 1'b1;
      m_pc    = 16'(m_pc + 16'd2);
    end else if (MemReady) begin
      m_paused = 1'b1;
    end else if (m_fv && !Stall) begin
      m_fv  = 1'b0;
      m_fir = NOP;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".MemReq"}, MemReq, !m_paused);
    if (!m_paused) chk({tag, ".MemAddr"}, MemAddr, m_pc);
    chk({tag, ".FValid"}, FValid, m_fv);
    chk({tag, ".FIR"}, FIR, m_fir);
    chk({tag, ".FPC"}, FPC, m_fpc);
    chk({tag, ".FPCP2"}, FPCP2, m_fpcp2);
    if (!FValid) chk({tag, ".bubble"}, FIR, NOP);
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic drive(input logic st, input logic rdy, input logic [15:0] data,
                       input logic br, input logic [15:0] tgt);
    Stall        = st;
    MemReady     = rdy;
    MemData      = data;
    BranchTaken  = br;
    BranchTarget = tgt;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all("reset");
    chk("reset.addr", MemAddr, RST_PC);

    // Zero-wait memory, constant data: back-to-back delivery from RESET_PC.
    Reset = 1'b1;
    drive(1'b0, 1'b1, 16'h9ABC, 1'b0, 16'h0000);
    chk("first_edge.req", MemReq, 1'b1);
    cycle("stream0");
    chk("stream.fpc0", FPC, 16'h0000);
    chk("stream.fpcp2_0", FPCP2, 16'h0002);
    chk("stream.fir0", FIR, 16'h9ABC);
    chk("stream.fv0", FValid, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      cycle("stream");
      chk("stream.fpc", FPC, 16'(2 * i));
    end

    // Stall for 3 cycles while a bundle is held.
    drive(1'b1, 1'b1, 16'h9ABC, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.fpc", FPC, 16'h0006);
      chk("stall.req", MemReq, 1'b0);
    end
    drive(1'b0, 1'b1, 16'h9ABC, 1'b0, 16'h0000);
    cycle("unstall");
    cycle("unstall_next");
    chk("unstall.fpc", FPC, 16'h0008);
    chk("unstall.fv", FValid, 1'b1);

    // Memory not ready for 4 cycles.
    drive(1'b0, 1'b0, 16'hDEAD, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle("wait");
      chk("wait.addr", MemAddr, 16'h000A);
      chk("wait.fv", FValid, 1'b0);
      chk("wait.fir", FIR, 16'h0000);
    end
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000);
    cycle("ready");
    chk("ready.fir", FIR, 16'h1234);
    chk("ready.fpc", FPC, 16'h000A);

    // Branch with ready and stall in the same cycle; odd target is aligned.
    drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 16'h5679);
    cycle("branch");
    chk("branch.fv", FValid, 1'b0);
    chk("branch.addr", MemAddr, 16'h5678);
    drive(1'b0, 1'b1, 16'h4321, 1'b0, 16'h0000);
    cycle("branch_fetch");
    chk("branch.fpc", FPC, 16'h5678);
    chk("branch.fir", FIR, 16'h4321);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 16'h1111, 1'b1, 16'hFFFE);
    cycle("wrap_br");
    drive(1'b0, 1'b1, 16'h2222, 1'b0, 16'h0000);
    cycle("wrap0");
    chk("wrap.fpc", FPC, 16'hFFFE);
    chk("wrap.fpcp2", FPCP2, 16'h0000);
    cycle("wrap1");
    chk("wrap.next_fpc", FPC, 16'h0000);

    // Asynchronous reset while parked in HOLD.
    drive(1'b1, 1'b1, 16'h3333, 1'b0, 16'h0000);
    cycle("to_hold");
    cycle("in_hold");
    chk("hold.req", MemReq, 1'b0);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.fv", FValid, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("rst_release.req", MemReq, 1'b1);
    chk("rst_release.addr", MemAddr, RST_PC);
    cycle("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 3) != 0, 16'($urandom),
            ($urandom % 16) == 0, 16'($urandom));
      if ((i % 500) == 250) begin
        drive(1'b0, 1'b1, 16'($urandom), 1'b1, 16'hFFFC);
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000: bubble instruction, equal to the IF/ID reset value.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Stall  input  1  downstream hold; this is the inverse of IF/ID RegWrite.
REQ-006 BranchTaken  input  1  redirect request from a later stage.
REQ-007 BranchTarget  input  16  redirect address.
REQ-008 MemReq  output  1  instruction memory read request.
REQ-009 MemAddr  output  16  instruction memory read address.
REQ-010 MemReady  input  1  MemData is valid this cycle for the current request.
REQ-011 MemData  input  16  instruction word.
REQ-012 FPC  output  16  PC of the delivered instruction; drives IF/ID IPC.
REQ-013 FPCP2  output  16  FPC+2; drives IF/ID IPCP2.
REQ-014 FIR  output  16  delivered instruction; drives IF/ID IIR.
REQ-015 FValid  output  1  the FPC/FPCP2/FIR bundle is a real instruction.

Function
REQ-016 The block SHALL hold an internal PC (next fetch address) and a two-state FSM: FETCH and HOLD.
REQ-017 In FETCH, MemReq SHALL be 1 and MemAddr SHALL equal PC; in HOLD, MemReq SHALL be 0.
REQ-018 In FETCH with MemReady=1 and BranchTaken=0, the next edge SHALL load: FPC<=PC, FPCP2<=PC+2, FIR<=MemData, FValid<=1 and PC<=PC+2.
REQ-019 The FETCH/MemReady=1 transfer SHALL occur only if the current bundle is consumed (FValid=0 or Stall=0); otherwise the FSM SHALL go to HOLD and MemData SHALL be dropped, with PC unchanged.
REQ-020 HOLD SHALL keep all F* outputs and PC stable and SHALL return to FETCH on the first cycle with Stall=0.
REQ-021 A bundle SHALL count as consumed at an edge where FValid=1 and Stall=0.
REQ-022 If no new instruction is loaded at that edge, FValid SHALL go to 0 and FIR SHALL go to NOP_INSTR.
REQ-023 In FETCH with MemReady=0, the block SHALL wait: MemAddr stays stable, and the F* outputs follow REQ-021/REQ-022.
REQ-024 BranchTaken=1 SHALL have priority over every other event.
REQ-025 On BranchTaken=1, the next edge SHALL load PC<={BranchTarget[15:1],1'b0}, FValid<=0, FIR<=NOP_INSTR, and state<=FETCH.
REQ-026 A BranchTaken edge SHALL discard any same-cycle MemData, regardless of Stall.
REQ-027 All PC arithmetic SHALL be modulo 2^16: 16'hFFFE+2 = 16'h0000, with no flag.
REQ-028 Throughput SHALL be one instruction per cycle with zero-wait memory and Stall=0.
REQ-029 Latency SHALL be one edge from MemReady=1 to FValid=1.
REQ-030 FValid=0 SHALL always coincide with FIR=NOP_INSTR.

Reset
REQ-031 Reset=0 SHALL immediately force: PC=RESET_PC, state=FETCH, FPC=0, FPCP2=0, FIR=NOP_INSTR, FValid=0.
REQ-032 Reset asserted mid-wait or mid-HOLD SHALL abandon the request; the block SHALL NOT wait for MemReady.
REQ-033 After Reset is released, the first active edge SHALL see MemReq=1 and MemAddr=RESET_PC.

Structure
REQ-034 The shared package miscv_pkg SHALL hold: instruction/address width 16, PC_INC=2, NOP_INSTR, RESET_PC, and the FSM state enum.
REQ-035 Next-PC selection (reset/branch/increment/hold) SHALL be placed in the sub-module if_pc_gen.
REQ-036 FSM and output registers SHALL live in if_fetch.

Verification
REQ-037 Reset, then release; memory always ready, returning MemData=16'h9ABC -> FValid=1 with FPC=0, FPCP2=2, FIR=16'h9ABC; then FPC=2, 4, 6 on consecutive edges.
REQ-038 Stall=1 for 3 cycles while FValid=1 -> F* outputs constant, MemReq=0 in HOLD; after release, the next FPC = previous FPC+2, with no instruction lost or duplicated.
REQ-039 MemReady=0 for 4 cycles -> MemAddr stable, FValid=0, FIR=16'h0000; on MemReady=1 with MemData=16'h1234 -> FIR=16'h1234 one edge later.
REQ-040 BranchTaken=1, BranchTarget=16'h5679, with MemReady=1 and Stall=1 in the same cycle -> next edge FValid=0, MemAddr=16'h5678; the following delivered FPC=16'h5678.
REQ-041 PC starts at 16'hFFFE (via branch), zero-wait memory -> FPC=16'hFFFE, FPCP2=16'h0000; next FPC=16'h0000.
REQ-042 Reset=0 asserted asynchronously mid-cycle during HOLD -> outputs go to reset values before the next edge; after release, MemAddr=RESET_PC.
